dmem_arbiter: RTL and testbench

Shares the single-port synchronous data memory between the pipeline MEM stage and a debug/loader port. CPU accesses have priority, and the debug port is guaranteed service through an aging counter. The block drives the memory control lines, stalls the pipeline when the CPU loses arbitration, and steers one-cycle-latency read data back to whichever requester issued the read. It sits between the MEM stage and the data-memory array.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_wait_counter.sv | 31 +++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dmem_arb_pkg;

  // Who owns the read data coming back from the array next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } rd_owner_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  // Byte address to word address; the caller keeps only the bits it needs,
  // so addresses wrap modulo the array size.
  function automatic logic [31:0] byte_to_word(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Saturating count of consecutive denied debug cycles; sat flags debug priority.
// Latency: count updates at the clock edge, sat is a decode of the current count.
// Backpressure: none; inc is ignored once saturated, clr wins over inc.
// Ports: clk, rst_n (sync, active-low), inc, clr in; sat out.
module dmem_wait_counter #(
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(DBG_MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CW'(DBG_MAX_WAIT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt == CW'(DBG_MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage (priority) and a
// debug/loader port that gains priority after DBG_MAX_WAIT denied cycles.
// Latency: grant/stall/memory controls combinational; read data returns the cycle after grant.
// Backpressure: cpu_stall holds the MEM stage when it loses; dbg_req is held until dbg_gnt.
// Ports: cpu_* (MEM stage request/return), dbg_* (debug request/grant/return),
//        mem_* (array control out, mem_rdata in), clk / rst_n (sync, active-low).
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              cpu_req;
  logic              dbg_pri;
  logic              cpu_win;
  logic              dbg_win;
  logic              win_we;
  logic [31:0]       win_addr;
  logic [31:0]       win_word;
  logic [DATA_W-1:0] win_wdata;
  rd_owner_t         rd_owner;
  rd_owner_t         rd_owner_nxt;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              cpu_ret;
  logic              dbg_ret;
  logic              unused_word_bits;

  // Read+write together is a store.
  assign cpu_req = cpu_mem_read | cpu_mem_write;

  // Gating with rst_n keeps every grant (and thus mem_en/mem_we/stall) low in reset.
  assign cpu_win = rst_n & cpu_req & ~(dbg_req & dbg_pri);
  assign dbg_win = rst_n & dbg_req & ~cpu_win;

  assign cpu_stall = rst_n & cpu_req & ~cpu_win;
  assign dbg_gnt   = dbg_win;

  dmem_wait_counter #(
    .DBG_MAX_WAIT (DBG_MAX_WAIT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dbg_req & ~dbg_win),
    .clr   (dbg_win | ~dbg_req),
    .sat   (dbg_pri)
  );

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (cpu_win) begin
      win_we    = cpu_mem_write;
      win_addr  = cpu_addr;
      win_wdata = cpu_wdata;
    end else if (dbg_win) begin
      win_we    = dbg_we;
      win_addr  = dbg_addr;
      win_wdata = dbg_wdata;
    end
  end

  assign win_word  = byte_to_word(win_addr);
  assign mem_en    = cpu_win | dbg_win;
  assign mem_we    = win_we;
  assign mem_addr  = win_word[ADDR_W-1:0];
  assign mem_wdata = win_wdata;

  // Word bits above the array size are dropped on purpose (address wrap).
  assign unused_word_bits = ^win_word[31:ADDR_W];

  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (cpu_win && !cpu_mem_write) begin
      rd_owner_nxt = OWN_CPU;
    end else if (dbg_win && !dbg_we) begin
      rd_owner_nxt = OWN_DBG;
    end
  end

  // The array presents read data during the cycle after the grant. The owner
  // sees it directly in that cycle; the hold registers capture it at the end of
  // that cycle so the value persists until the owner's next read return.
  // A reset in the return cycle suppresses the return and clears the holds.
  assign cpu_ret = rst_n & (rd_owner == OWN_CPU);
  assign dbg_ret = rst_n & (rd_owner == OWN_DBG);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_owner    <= OWN_NONE;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      rd_owner <= rd_owner_nxt;
      if (cpu_ret) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (dbg_ret) begin
        dbg_rdata_q <= mem_rdata;
      end
    end
  end

  assign cpu_rdata  = cpu_ret ? mem_rdata : cpu_rdata_q;
  assign dbg_rvalid = dbg_ret;
  assign dbg_rdata  = dbg_ret ? mem_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a synchronous memory array, a transaction-level
// reference model (priority/aging rule, word-addressed shadow memory, one pending
// return) and directed plus randomized stimulus checked every cycle.
module tb_dmem_arbiter;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_mem_read, cpu_mem_write;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_stall;
  logic              dbg_req, dbg_we;
  logic [31:0]       dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic              dbg_gnt, dbg_rvalid;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .DBG_MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_mem_read  (cpu_mem_read),
    .cpu_mem_write (cpu_mem_write),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .dbg_req       (dbg_req),
    .dbg_we        (dbg_we),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_gnt       (dbg_gnt),
    .dbg_rvalid    (dbg_rvalid),
    .dbg_rdata     (dbg_rdata),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  // Single-port synchronous array driven only by the DUT.
  logic [DATA_W-1:0] tb_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata        <= tb_mem[mem_addr];
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int unsigned       m_wait      = 0;
  int unsigned       m_owner     = 0;   // 0 none, 1 cpu, 2 debug
  logic [DATA_W-1:0] m_rd_data   = '0;
  logic [DATA_W-1:0] m_cpu_hold  = '0;
  logic [DATA_W-1:0] m_dbg_hold  = '0;
  logic              m_last_dgnt = 1'b0;
  logic              m_last_stall = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check all outputs mid-cycle
  // against the model, then advance the model to the next edge.
  task automatic step(input logic rn, input logic cr, input logic cw,
                      input logic [31:0] ca, input logic [31:0] cwd,
                      input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd);
    logic e_cg, e_dg, e_stall, e_we, e_dv;
    logic [31:0] e_wd, e_crd, e_drd;
    int unsigned e_addr;
    @(posedge clk);
    #1;
    rst_n = rn; cpu_mem_read = cr; cpu_mem_write = cw; cpu_addr = ca; cpu_wdata = cwd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dwd;
    #1;
    e_cg    = rn && (cr || cw) && !(dr && (m_wait == MAX_WAIT));
    e_dg    = rn && dr && !e_cg;
    e_stall = rn && (cr || cw) && !e_cg;
    e_we    = e_cg ? cw : (e_dg ? dw : 1'b0);
    e_addr  = e_cg ? (ca / 4) % DEPTH : (e_dg ? (da / 4) % DEPTH : 0);
    e_wd    = e_cg ? cwd : (e_dg ? dwd : 32'h0);
    e_crd   = (rn && m_owner == 1) ? m_rd_data : m_cpu_hold;
    e_dv    = rn && (m_owner == 2);
    e_drd   = e_dv ? m_rd_data : m_dbg_hold;
    chk("dbg_gnt",    dbg_gnt,    e_dg);
    chk("cpu_stall",  cpu_stall,  e_stall);
    chk("mem_en",     mem_en,     e_cg || e_dg);
    chk("mem_we",     mem_we,     e_we);
    chk("mem_addr",   mem_addr,   e_addr);
    chk("mem_wdata",  mem_wdata,  e_wd);
    chk("cpu_rdata",  cpu_rdata,  e_crd);
    chk("dbg_rvalid", dbg_rvalid, e_dv);
    chk("dbg_rdata",  dbg_rdata,  e_drd);
    m_last_dgnt  = e_dg;
    m_last_stall = e_stall;
    if (!rn) begin
      m_wait = 0; m_owner = 0; m_cpu_hold = '0; m_dbg_hold = '0;
    end else begin
      if (m_owner == 1) m_cpu_hold = m_rd_data;
      if (m_owner == 2) m_dbg_hold = m_rd_data;
      if (e_dg || !dr)            m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
      m_owner = 0;
      if (e_cg || e_dg) begin
        if (e_we) ref_mem[e_addr] = e_wd;
        else begin
          m_owner   = e_cg ? 1 : 2;
          m_rd_data = ref_mem[e_addr];
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return $urandom();
    return 32'($urandom_range(0, 127));
  endfunction

  logic        rrn, rcr, rcw, rdr, rdw;
  logic [31:0] rca, rcwd, rda, rdwd;

  initial begin
    rst_n = 1'b0; cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // Reset with requests pending: everything must stay quiet.
    step(1'b0, 1'b1, 1'b1, 32'h10, 32'h55, 1'b1, 1'b1, 32'h4, 32'h66);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);

    // Known contents everywhere through the debug port.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'(i * 4), $urandom());

    // Store then load at byte 20 (word 5).
    step(1'b1, 1'b0, 1'b1, 32'd20, 32'hABCD1234, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("st_addr", mem_addr, 8'd5);
    chk("st_stall", cpu_stall, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("ld_addr", mem_addr, 8'd5);
    idle();
    chk("ld_data", cpu_rdata, 32'hABCD1234);

    // Debug write then read at byte 8, CPU idle.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'd8, 32'h0000BEEF);
    chk("dw_gnt", dbg_gnt, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd8, 32'h0);
    idle();
    chk("dr_valid", dbg_rvalid, 1'b1);
    chk("dr_data", dbg_rdata, 32'h0000BEEF);
    chk("dr_cpu_kept", cpu_rdata, 32'hABCD1234);
    idle();
    chk("dr_pulse", dbg_rvalid, 1'b0);

    // Continuous contention: debug denied MAX_WAIT cycles, wins the next.
    for (int i = 0; i <= MAX_WAIT; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'd20, 32'h0, 1'b1, 1'b0, 32'd8, 32'h0);
      chk("age_gnt", dbg_gnt, (i == MAX_WAIT));
      chk("age_stall", cpu_stall, (i == MAX_WAIT));
    end
    step(1'b1, 1'b1, 1'b0, 32'd20, 32'h0, 1'b1, 1'b0, 32'd8, 32'h0);
    chk("age_cleared", dbg_gnt, 1'b0);
    idle();

    // Alternating reads: CPU then debug, returns steered separately.
    step(1'b1, 1'b1, 1'b0, 32'd20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd8, 32'h0);
    chk("alt_cpu", cpu_rdata, 32'hABCD1234);
    chk("alt_no_dv", dbg_rvalid, 1'b0);
    idle();
    chk("alt_dbg", dbg_rdata, 32'h0000BEEF);
    chk("alt_cpu_kept", cpu_rdata, 32'hABCD1234);

    // Reset in the return cycle of a debug read.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd8, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rr_no_dv", dbg_rvalid, 1'b0);
    idle();
    chk("rr_dv", dbg_rvalid, 1'b0);
    chk("rr_drd", dbg_rdata, 32'h0);
    chk("rr_crd", cpu_rdata, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'd20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    chk("rr_reload", cpu_rdata, 32'hABCD1234);

    // Read+write together is a store; 0x404 wraps to word 1.
    step(1'b1, 1'b1, 1'b1, 32'h404, 32'h13579BDF, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap_we", mem_we, 1'b1);
    chk("wrap_addr", mem_addr, 8'd1);
    step(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    chk("wrap_data", cpu_rdata, 32'h13579BDF);

    // Randomized traffic obeying the hold-while-stalled / hold-until-grant rules.
    rcr = 1'b0; rcw = 1'b0; rca = '0; rcwd = '0;
    rdr = 1'b0; rdw = 1'b0; rda = '0; rdwd = '0;
    for (int i = 0; i < 3000; i++) begin
      rrn = ($urandom_range(0, 199) != 0);
      if (!m_last_stall) begin
        rcr = ($urandom_range(0, 2) != 0); rcw = ($urandom_range(0, 3) == 0);
        rca = rnd_addr(); rcwd = $urandom();
      end
      if (!(rdr && !m_last_dgnt) || $urandom_range(0, 15) == 0) begin
        rdr = ($urandom_range(0, 1) == 1); rdw = ($urandom_range(0, 1) == 1);
        rda = rnd_addr(); rdwd = $urandom();
      end
      step(rrn, rcr, rcw, rca, rcwd, rdr, rdw, rda, rdwd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
